// File: rtl/multiplier.sv
// Sequential shift-add multiply-accumulator: A = Q*B + R, one multiplier bit per clock.
// Inverse companion of the restoring divider; start is a level-sampled button in WAIT.
module multiplier #(
  parameter int n = 6
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           BTN,
  input  logic [n-1:0]   Q,
  input  logic [n-1:0]   B,
  input  logic [n-1:0]   R,
  output logic [2*n-1:0] A,
  output logic           BUSY,
  output logic           DONE
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  typedef enum logic [1:0] {
    st_WAIT = 2'd0,
    st_ADD  = 2'd1,
    st_DONE = 2'd2
  } state_t;

  state_t         ps_q, ps_d;
  logic [2*n-1:0] mcand_q, mcand_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [2*n-1:0] a_q, a_d;
  logic [n-1:0]   mq_q, mq_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*n-1:0] sum;

  // Partial sum for the current multiplier bit; the carry-out cannot occur.
  assign sum = mq_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ps_q    <= st_WAIT;
      mcand_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ps_q    <= ps_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ps_d    = ps_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    a_d     = a_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    case (ps_q)
      st_WAIT: begin
        if (BTN) begin
          mcand_d = {{n{1'b0}}, B};
          mq_d    = Q;
          acc_d   = {{n{1'b0}}, R};
          cnt_d   = '0;
          ps_d    = st_ADD;
        end
      end
      st_ADD: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mq_d    = mq_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          a_d  = sum;
          ps_d = st_DONE;
        end
      end
      st_DONE: ps_d = st_WAIT;
      default: ps_d = st_WAIT;
    endcase
  end

  assign A    = a_q;
  assign BUSY = (ps_q == st_ADD);
  assign DONE = (ps_q == st_DONE);

endmodule

// File: tb/tb_multiplier.sv
// Randomised and directed bench for multiplier: a cycle-level model of the
// operation timeline is compared against A/BUSY/DONE on every falling edge.
module tb_multiplier;
  localparam int N = 6;

  logic           CLK = 1'b0;
  logic           CLR = 1'b0;
  logic           BTN = 1'b0;
  logic [N-1:0]   Q = '0, B = '0, R = '0;
  logic [2*N-1:0] A;
  logic           BUSY, DONE;

  int nvec = 0;
  int nerr = 0;

  multiplier #(.n(N)) dut (
    .CLK(CLK), .CLR(CLR), .BTN(BTN), .Q(Q), .B(B), .R(R),
    .A(A), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Model: phase 0 = idle, 1..N = edges elapsed in the add sequence, N+1 = result cycle.
  int             phase = 0;
  logic [2*N-1:0] exp_a = '0;
  logic [2*N-1:0] pend  = '0;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      phase <= 0;
      exp_a <= '0;
      pend  <= '0;
    end else if (phase == 0) begin
      if (BTN) begin
        phase <= 1;
        pend  <= (2*N)'(int'(Q) * int'(B) + int'(R));
      end
    end else if (phase < N) begin
      phase <= phase + 1;
    end else if (phase == N) begin
      phase <= N + 1;
      exp_a <= pend;
    end else begin
      phase <= 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("cyc_A", 64'(A), 64'(exp_a));
    chk("cyc_BUSY", 64'(BUSY), 64'(phase >= 1 && phase <= N));
    chk("cyc_DONE", 64'(DONE), 64'(phase == N + 1));
    chk("cyc_no_overlap", 64'(BUSY && DONE), 64'd0);
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Starts from WAIT, pulses BTN for one cycle, returns after the DONE cycle.
  task automatic run_op(input int q, input int b, input int r, input int req,
                        input string nm, output int busy_cycles);
    int k;
    Q = N'(q); B = N'(b); R = N'(r); BTN = 1'b1;
    step();
    BTN = 1'b0;
    k = 0;
    busy_cycles = 0;
    while (DONE !== 1'b1 && k < 3 * N) begin
      if (BUSY === 1'b1) busy_cycles++;
      step();
      k++;
    end
    chk({nm, "_done_seen"}, 64'(DONE), 64'd1);
    chk(nm, 64'(A), 64'(req));
    step();
  endtask

  initial begin
    int bc, last_done, ndone;
    #2 CLR = 1'b1;
    step();
    step();
    chk("reset_A", 64'(A), 64'd0);
    chk("reset_BUSY", 64'(BUSY), 64'd0);
    chk("reset_DONE", 64'(DONE), 64'd0);
    CLR = 1'b0;
    step();

    run_op(5, 9, 3, 48, "basic", bc);
    chk("basic_busy_len", 64'(bc), 64'(N));
    for (int i = 0; i < 4; i++) step();
    chk("basic_hold", 64'(A), 64'd48);

    run_op(63, 63, 63, 4032, "max", bc);
    run_op(0, 17, 4, 4, "zero_q", bc);
    run_op(0, 0, 0, 0, "all_zero", bc);
    run_op(6, 7, 3, 45, "round_trip", bc);

    for (int bb = 1; bb <= 63; bb++)
      run_op(63 - bb, bb, bb - 1, (63 - bb) * bb + bb - 1, "sweep", bc);

    // Operand and BTN changes during the add sequence must be ignored.
    Q = 10; B = 10; R = 0; BTN = 1'b1;
    step();
    BTN = 1'b0;
    Q = 6'd33; B = 6'd21; R = 6'd7;
    step();
    BTN = 1'b1;
    step();
    BTN = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      step();
      if (DONE === 1'b1) begin
        ndone++;
        chk("midchange_A", 64'(A), 64'd100);
      end
    end
    chk("midchange_single_done", 64'(ndone), 64'd1);

    // Held BTN: back-to-back operations every N+2 cycles.
    Q = 2; B = 3; R = 1; BTN = 1'b1;
    last_done = -1;
    ndone = 0;
    for (int i = 0; i < 4 * (N + 2); i++) begin
      step();
      if (DONE === 1'b1) begin
        chk("held_A", 64'(A), 64'd7);
        if (last_done >= 0) chk("held_period", 64'(i - last_done), 64'(N + 2));
        last_done = i;
        ndone++;
      end
    end
    chk("held_done_count", 64'(ndone), 64'd4);
    BTN = 1'b0;
    for (int i = 0; i < 2 * (N + 2); i++) step();

    repeat (40) begin
      int q, b, r;
      q = $urandom_range(0, 63);
      b = $urandom_range(0, 63);
      r = $urandom_range(0, 63);
      run_op(q, b, r, q * b + r, "random", bc);
    end

    // Asynchronous abort mid-add.
    Q = 45; B = 50; R = 9; BTN = 1'b1;
    step();
    BTN = 1'b0;
    step();
    step();
    chk("abort_busy_before", 64'(BUSY), 64'd1);
    #2 CLR = 1'b1;
    #1;
    chk("abort_A", 64'(A), 64'd0);
    chk("abort_BUSY", 64'(BUSY), 64'd0);
    chk("abort_DONE", 64'(DONE), 64'd0);
    step();
    CLR = 1'b0;
    ndone = 0;
    for (int i = 0; i < N + 4; i++) begin
      step();
      if (DONE === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(3, 4, 5, 17, "after_abort", bc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
